// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
//   - op encodings carried on the 3-bit op port (6/7 are reserved no-ops)
//   - sequencer state encoding
//   - width of the busy-cycle counter
package mdu_pkg;

   localparam int CNT_W = 4;

   typedef enum logic [2:0] {
      MDU_MULT  = 3'd0,
      MDU_MULTU = 3'd1,
      MDU_DIV   = 3'd2,
      MDU_DIVU  = 3'd3,
      MDU_MTHI  = 3'd4,
      MDU_MTLO  = 3'd5
   } mdu_op_e;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } mdu_state_e;

endpackage

// File: rtl/mdu_calc.sv
// Combinational multiply/divide datapath.
// Ports:
//   op     in  3   latched command (only MULT/MULTU/DIV/DIVU are meaningful)
//   a      in  32  latched operand rs
//   b      in  32  latched operand rt
//   result out 64  {hi,lo}: product for multiplies, {remainder,quotient} for divides
//   div0   out 1   divide command with a zero divisor
module mdu_calc
   import mdu_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [63:0] result,
   output logic        div0
);

   logic        is_signed;
   logic        is_mul;
   logic [63:0] a_ext;
   logic [63:0] b_ext;
   logic [63:0] prod;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] divisor;
   logic [31:0] quo_mag;
   logic [31:0] rem_mag;
   logic [31:0] quo;
   logic [31:0] rem;
   logic        neg_q;
   logic        neg_r;

   always_comb begin
      is_signed = (op == MDU_MULT) || (op == MDU_DIV);
      is_mul    = (op == MDU_MULT) || (op == MDU_MULTU);

      // Sign-extending to 64 bits makes the low 64 bits of an unsigned
      // multiply equal to the two's-complement signed product.
      a_ext = {{32{is_signed & a[31]}}, a};
      b_ext = {{32{is_signed & b[31]}}, b};
      prod  = a_ext * b_ext;

      // Signed divide via magnitudes: quotient truncates toward zero,
      // remainder takes the dividend's sign. 0x80000000 / -1 falls out
      // naturally as quotient 0x80000000, remainder 0.
      a_mag   = (is_signed && a[31]) ? (32'd0 - a) : a;
      b_mag   = (is_signed && b[31]) ? (32'd0 - b) : b;
      // Zero divisor is replaced so the divider never sees it; the result
      // is discarded via div0 anyway.
      divisor = (b_mag == 32'd0) ? 32'd1 : b_mag;
      quo_mag = a_mag / divisor;
      rem_mag = a_mag % divisor;
      neg_q   = is_signed && (a[31] ^ b[31]);
      neg_r   = is_signed && a[31];
      quo     = neg_q ? (32'd0 - quo_mag) : quo_mag;
      rem     = neg_r ? (32'd0 - rem_mag) : rem_mag;

      div0   = ((op == MDU_DIV) || (op == MDU_DIVU)) && (b == 32'd0);
      result = is_mul ? prod : {rem, quo};
   end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide sequencer with HI/LO register pair.
// One command is accepted per start pulse while idle; busy stays high for a
// fixed latency, then HI/LO commit and done pulses for one cycle.
// Optional feature macro: MDU_ABORT_EN adds the abort port (flushes an
// in-flight operation without touching HI/LO).
// Ports:
//   clk    in  1   rising-edge clock
//   reset  in  1   synchronous active-high reset, clears all state
//   start  in  1   command valid this cycle (ignored while busy)
//   op     in  3   command encoding (see mdu_pkg)
//   a      in  32  operand rs
//   b      in  32  operand rt
//   abort  in  1   (MDU_ABORT_EN only) cancel in-flight operation
//   busy   out 1   operation in flight
//   done   out 1   one-cycle pulse, HI/LO updated this cycle
//   hi     out 32  HI register
//   lo     out 32  LO register
// Handshake: start is a one-shot request with no ready; it is accepted only
// when busy is low (including the cycle done is high) and is otherwise dropped.
module mdu_ctrl
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
`ifdef MDU_ABORT_EN
   input  logic        abort,
`endif
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   mdu_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       op_q, op_d;
   logic [31:0]      a_q, a_d;
   logic [31:0]      b_q, b_d;
   logic [31:0]      hi_q, hi_d;
   logic [31:0]      lo_q, lo_d;
   logic             done_q, done_d;
   logic             abort_req;
   logic [63:0]      calc_result;
   logic             calc_div0;

`ifdef MDU_ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   mdu_calc u_calc (
      .op     (op_q),
      .a      (a_q),
      .b      (b_q),
      .result (calc_result),
      .div0   (calc_div0)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            // An abort coinciding with start suppresses the start.
            if (start && !abort_req) begin
               case (op)
                  MDU_MULT, MDU_MULTU: begin
                     state_d = RUN;
                     cnt_d   = CNT_W'(MULT_CYCLES);
                     op_d    = op;
                     a_d     = a;
                     b_d     = b;
                  end
                  MDU_DIV, MDU_DIVU: begin
                     state_d = RUN;
                     cnt_d   = CNT_W'(DIV_CYCLES);
                     op_d    = op;
                     a_d     = a;
                     b_d     = b;
                  end
                  MDU_MTHI: hi_d = a;
                  MDU_MTLO: lo_d = a;
                  default: ;
               endcase
            end
         end
         RUN: begin
            if (abort_req) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(1)) begin
               state_d = IDLE;
               cnt_d   = '0;
               done_d  = 1'b1;
               if (!calc_div0) begin
                  {hi_d, lo_d} = calc_result;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q == RUN);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
module tb_mdu_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        abort;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
`ifdef MDU_ABORT_EN
    .abort (abort),
`endif
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // monitor / scoreboard: every done pulse must match the oldest expected {hi,lo}
  always @(negedge clk) begin
    if (!reset) begin
      if (busy && done) begin
        checks++;
        errors++;
        $display("FAIL busy_done_overlap: busy=%0b done=%0b", busy, done);
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: hi/lo=0x%0h with nothing expected", {hi, lo});
        end else begin
          check("done_hilo", {hi, lo}, exp_q.pop_front());
        end
      end
    end
  end

  // driver: caller is at a negedge; issues a long op and waits until it completes
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input int n, input logic [31:0] eh,
                        input logic [31:0] el);
    int cnt;
    exp_q.push_back({eh, el});
    m_hi = eh;
    m_lo = el;
    start = 1'b1; op = o; a = av; b = bv;
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom;   // operands must already be latched
    cnt = 0;
    while (busy && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    check({name, "_busy_cycles"}, 64'(cnt), 64'(n));
    check({name, "_done"}, 64'(done), 64'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int cnt;
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; abort = 1'b0;
    idle(3);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;
    idle(1);

    // multiplies and divides, chained so each starts in the previous done cycle
    run_op("mult_neg",  OP_MULT,  32'hFFFFFFFE, 32'd3, MULT_N, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'd2, MULT_N, 32'h00000001, 32'hFFFFFFFE);
    run_op("div_neg",   OP_DIV,   32'hFFFFFFF9, 32'd2, DIV_N,  32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu_zero", OP_DIVU,  32'd7,        32'd0, DIV_N,  32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_ovf",   OP_DIV,   32'h80000000, 32'hFFFFFFFF, DIV_N, 32'h0, 32'h80000000);
    run_op("divu",      OP_DIVU,  32'd100,      32'd7, DIV_N,  32'd2, 32'd14);
    run_op("div_negb",  OP_DIV,   32'd7,        32'hFFFFFFFE, DIV_N, 32'd1, 32'hFFFFFFFD);
    run_op("mult_big",  OP_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, MULT_N, 32'h3FFFFFFF, 32'h00000001);
    run_op("div_zero",  OP_DIV,   32'h12345678, 32'd0, DIV_N,  32'h3FFFFFFF, 32'h00000001);
    idle(2);

    // MTHI then MTLO on consecutive cycles; busy never rises
    start = 1'b1; op = OP_MTHI; a = 32'h1234;
    @(negedge clk);
    check("mthi_busy", 64'(busy), 64'd0);
    op = OP_MTLO; a = 32'h5678;
    @(negedge clk);
    start = 1'b0;
    check("mtlo_busy", 64'(busy), 64'd0);
    check("mt_hilo", {hi, lo}, {32'h1234, 32'h5678});
    m_hi = 32'h1234; m_lo = 32'h5678;
    idle(1);
    check("mt_busy_after", 64'(busy), 64'd0);

    // reserved ops 6 and 7 do nothing
    start = 1'b1; op = 3'd6; a = 32'hDEAD; b = 32'hBEEF;
    @(negedge clk);
    op = 3'd7;
    @(negedge clk);
    start = 1'b0;
    idle(1);
    check("rsvd_busy", 64'(busy), 64'd0);
    check("rsvd_hilo", {hi, lo}, {m_hi, m_lo});

    // second start during busy cycle 2 is dropped
    exp_q.push_back({32'd0, 32'd12});
    m_hi = 32'd0; m_lo = 32'd12;
    start = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; a = 32'd5; b = 32'd6;
    @(negedge clk);
    start = 1'b0;
    cnt = 3;
    while (busy && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    check("ignored_busy_cycles", 64'(cnt), 64'(MULT_N + 1));
    check("ignored_hilo", {hi, lo}, {32'd0, 32'd12});
    idle(8);
    check("ignored_no_restart", 64'(busy), 64'd0);

    // reset at busy cycle 3 of a DIV
    start = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    idle(2);
    check("pre_reset_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_done", 64'(done), 64'd0);
    check("midreset_hilo", {hi, lo}, 64'd0);
    idle(DIV_N + 2);

`ifdef MDU_ABORT_EN
    // abort keeps HI/LO and produces no done
    start = 1'b1; op = OP_MTHI; a = 32'hAAAA0001;
    @(negedge clk);
    op = OP_MTLO; a = 32'hBBBB0002;
    @(negedge clk);
    op = OP_DIV; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    idle(2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hilo", {hi, lo}, {32'hAAAA0001, 32'hBBBB0002});
    // abort with start in idle: start is suppressed
    start = 1'b1; abort = 1'b1; op = OP_MTHI; a = 32'h5555;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("abort_start_hi", 64'(hi), 64'(32'hAAAA0001));
    idle(DIV_N + 2);
`endif

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
